pipeline_hazard_ctrl: RTL
=========================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Sequences the four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) of the 5-stage RISC-V core.
//  Generates each register's enable/clear pair plus pc_en, covering load-use stalls, taken-branch flushes and
//  data-memory wait states. Memory waits are watched by a timeout FSM that halts the core on a hung access.
//  Sits in the ID/EX control area; consumes decoded register indices from ID, EX and MEM.
// PARAMETERS
//  MEM_TIMEOUT  16  consecutive wait cycles before ERROR (>=2)
//  CNT_W        32  width of stall_cycles performance counter
// PORTS
//  clk           in   1      core clock, all state on rising edge
//  reset         in   1      synchronous, active-low
//  id_rs1,id_rs2 in   5      source register indices of instruction in ID
//  id_use_rs1/2  in   1      instruction in ID actually reads rs1/rs2
//  ex_rd         in   5      destination of instruction in EX
//  ex_regwrite   in   1      EX instruction writes rd
//  ex_memread    in   1      EX instruction is a load
//  mem_rd        in   5      destination of instruction in MEM
//  mem_regwrite  in   1      MEM instruction writes rd
//  branch_taken  in   1      EX resolved taken branch/jump (PC redirect this cycle)
//  mem_req       in   1      MEM stage is issuing a data-memory access
//  mem_ready     in   1      data memory completes access this cycle
//  pc_en         out  1      PC update enable
//  ifid_en/clr, idex_en/clr, exmem_en/clr, memwb_en/clr  out 1 each  pipeline register controls
//  mem_err       out  1      sticky: memory timeout, core halted
//  stall_cycles  out  CNT_W  saturating count of cycles with pc_en=0
// BEHAVIOUR
//  - Pipeline register semantics: clr acts only when en=1; flush = en=1,clr=1; freeze = en=0.
//  - All control outputs combinational from inputs + state. While reset=0: all en/clr=0.
//  - Sync reset (edge with reset=0): state=RUN, wait_cnt=0, mem_err=0, stall_cycles=0.
//  - mem_stall = mem_req & !mem_ready. hz = ex_memread & ex_regwrite & ex_rd!=0 & match, where
//    match = (id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd). x0 never hazards.
//  - Priority per cycle (state RUN/MEM_WAIT): mem_stall > branch_taken > hz > normal.
//    mem_stall: pc,ifid,idex,exmem en=0; memwb en=1 clr=1 (bubble to WB).
//    branch_taken: all en=1; ifid_clr=idex_clr=1 (kill 2 younger instrs); pc loads target.
//    hz: pc_en=ifid_en=0; idex en=1 clr=1; exmem,memwb en=1 clr=0. Exactly 1 bubble.
//    normal: all en=1, all clr=0.
//  - branch_taken during mem_stall is ignored this cycle; EX is frozen, so it re-presents after ready.
//  - FSM: RUN -> MEM_WAIT when mem_stall; MEM_WAIT -> RUN when !mem_stall (wait_cnt<=0).
//    wait_cnt increments each mem_stall cycle; mem_stall with wait_cnt==MEM_TIMEOUT-1 -> ERROR.
//    mem_ready on that last cycle completes normally (no error). ERROR: all en=0, mem_err=1, until reset.
//  - stall_cycles +1 each cycle with reset=1 and pc_en=0 (incl. ERROR); saturates at all-ones.
// CONFIGURATION
//  FORWARDING_EN defined: hazard detection as above (full EX/MEM->EX forwarding exists in datapath).
//  FORWARDING_EN undefined: hz also asserted for any ex_regwrite match (not only loads) and for
//    mem_regwrite & mem_rd!=0 match on rs1/rs2; stall repeats each cycle until producer reaches WB.
//    Register file is write-before-read, so WB never hazards.
// TESTING
//  1. ld x5 in EX, ID add x6,x5,x1 (use_rs1) -> one cycle pc_en=0,ifid_en=0,idex_clr=1; next cycle normal.
//  2. branch_taken=1, no stall -> ifid_clr=idex_clr=1, all en=1, pc_en=1 for one cycle.
//  3. mem_req=1, mem_ready low 3 cycles then high -> 3 cycles freeze + memwb bubble, stall_cycles+=3, state RUN.
//  4. mem_ready never high, MEM_TIMEOUT=16 -> ERROR after 16th cycle, mem_err=1, all en=0; reset clears.
//  5. hz with ex_rd=0 -> no stall; hz + branch_taken same cycle -> flush only, no pc stall.
//  6. !FORWARDING_EN: add x5 in MEM, ID reads x5 -> stall 1 cycle; add in EX -> stall 2 cycles.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline register sequencing for the 5-stage core: load-use stalls, branch flushes, memory waits and hung-access halt.
// Optional macro FORWARDING_EN: when defined, only load-use in EX stalls; otherwise EX and MEM producers stall ID.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_regwrite,
    input  logic             ex_memread,
    input  logic [4:0]       mem_rd,
    input  logic             mem_regwrite,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_clr,
    output logic             idex_en,
    output logic             idex_clr,
    output logic             exmem_en,
    output logic             exmem_clr,
    output logic             memwb_en,
    output logic             memwb_clr,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int WC_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } state_t;

    state_t            state_reg;
    logic [WC_W-1:0]   wait_cnt_reg;
    logic              mem_err_reg;
    logic [CNT_W-1:0]  stall_cycles_reg;

    logic mem_stall;
    logic match_ex;
    logic match_mem;
    logic hz;

    assign mem_stall = mem_req & ~mem_ready;
    assign match_ex  = (id_use_rs1 & (id_rs1 == ex_rd))  | (id_use_rs2 & (id_rs2 == ex_rd));
    assign match_mem = (id_use_rs1 & (id_rs1 == mem_rd)) | (id_use_rs2 & (id_rs2 == mem_rd));

`ifdef FORWARDING_EN
    // Forwarding covers everything except a load result needed in the very next cycle.
    assign hz = ex_memread & ex_regwrite & (ex_rd != 5'd0) & match_ex;
`else
    // No bypass paths: any in-flight writer ahead of WB blocks the reader; WB writes before ID reads.
    assign hz = (ex_regwrite & (ex_rd != 5'd0) & match_ex)
              | (mem_regwrite & (mem_rd != 5'd0) & match_mem);
    logic unused_memread;
    assign unused_memread = ex_memread;
`endif

    always_comb begin
        pc_en     = 1'b0;
        ifid_en   = 1'b0;
        ifid_clr  = 1'b0;
        idex_en   = 1'b0;
        idex_clr  = 1'b0;
        exmem_en  = 1'b0;
        exmem_clr = 1'b0;
        memwb_en  = 1'b0;
        memwb_clr = 1'b0;
        if (reset && (state_reg != ST_ERROR)) begin
            if (mem_stall) begin
                // Everything upstream of MEM holds; WB receives a bubble.
                memwb_en  = 1'b1;
                memwb_clr = 1'b1;
            end else if (branch_taken) begin
                pc_en    = 1'b1;
                ifid_en  = 1'b1;
                ifid_clr = 1'b1;
                idex_en  = 1'b1;
                idex_clr = 1'b1;
                exmem_en = 1'b1;
                memwb_en = 1'b1;
            end else if (hz) begin
                idex_en  = 1'b1;
                idex_clr = 1'b1;
                exmem_en = 1'b1;
                memwb_en = 1'b1;
            end else begin
                pc_en    = 1'b1;
                ifid_en  = 1'b1;
                idex_en  = 1'b1;
                exmem_en = 1'b1;
                memwb_en = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg        <= ST_RUN;
            wait_cnt_reg     <= '0;
            mem_err_reg      <= 1'b0;
            stall_cycles_reg <= '0;
        end else begin
            if (!pc_en && (stall_cycles_reg != '1))
                stall_cycles_reg <= stall_cycles_reg + CNT_W'(1);
            case (state_reg)
                ST_RUN, ST_MEM_WAIT: begin
                    if (mem_stall) begin
                        if (wait_cnt_reg == WAIT_LAST) begin
                            state_reg   <= ST_ERROR;
                            mem_err_reg <= 1'b1;
                        end else begin
                            state_reg    <= ST_MEM_WAIT;
                            wait_cnt_reg <= wait_cnt_reg + WC_W'(1);
                        end
                    end else begin
                        state_reg    <= ST_RUN;
                        wait_cnt_reg <= '0;
                    end
                end
                // Halted (or illegal encoding): stay stopped until reset.
                default: begin
                    state_reg   <= ST_ERROR;
                    mem_err_reg <= 1'b1;
                end
            endcase
        end
    end

    assign mem_err      = mem_err_reg;
    assign stall_cycles = stall_cycles_reg;

endmodule
